// File: rtl/sample_pulse_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sample_pulse_scheduler
//  Purpose  : Round-robin arbiter sharing one sample-pulse one-shot among
//             N_REQ requesters. Drives the gate/trigger pins, tracks the returned
//             pulse through its rise and fall, then acks the owner. A pulse that
//             never starts or never ends is aborted and flagged as a fault.
//  Revision : 1.0 - initial release
// ============================================================================
module sample_pulse_scheduler #(
    parameter int N_REQ    = 4,
    parameter int START_TO = 6,
    parameter int WIDTH_TO = 8,
    parameter int GAP      = 2
) (
    input  logic             x,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] ack,
    output logic             fault,
    output logic             busy,
    output logic             gate_c,
    output logic             trig_b,
    input  logic             pulse_in
);

    // Pointer width and timer width; the timer also counts the recovery gap,
    // so its range covers GAP as well as both timeouts.
    localparam int c_PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_TM0  = (START_TO > WIDTH_TO) ? START_TO : WIDTH_TO;
    localparam int c_TMAX = (c_TM0 > GAP) ? c_TM0 : GAP;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    localparam logic [c_TW-1:0] c_START_LAST = c_TW'(START_TO - 1);
    localparam logic [c_TW-1:0] c_WIDTH_LAST = c_TW'(WIDTH_TO - 1);
    localparam logic [c_TW-1:0] c_GAP_LAST   = c_TW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [c_TW-1:0] c_TIMER_SAT  = {c_TW{1'b1}};
    localparam logic [c_PW-1:0] c_LAST_REQ   = c_PW'(N_REQ - 1);
    localparam logic [c_PW:0]   c_NREQ_EXT   = (c_PW + 1)'(N_REQ);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_DONE    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [c_TW-1:0]  r_timer, w_timer_nxt, w_timer_inc;
    logic [c_PW-1:0]  r_rr, w_rr_nxt, w_rr_inc, w_win;
    logic [c_PW:0]    w_idx;
    logic             w_found;
    logic [N_REQ-1:0] w_win_oh;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [N_REQ-1:0] r_ack, w_ack_nxt;
    logic             r_fault, w_fault_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_gate, w_gate_nxt;
    logic             r_trig, w_trig_nxt;

    // Round-robin pick: first asserted request at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, r_rr} + (c_PW + 1)'(k);
            if (w_idx >= c_NREQ_EXT) begin
                w_idx = w_idx - c_NREQ_EXT;
            end
            if (!w_found && req[w_idx[c_PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[c_PW-1:0];
            end
        end
    end

    // Winner decode, pointer advance and saturating timer increment.
    always_comb begin
        w_win_oh        = '0;
        w_win_oh[w_win] = 1'b1;
        w_rr_inc        = (w_win == c_LAST_REQ) ? '0 : w_win + c_PW'(1);
        w_timer_inc     = (r_timer == c_TIMER_SAT) ? r_timer : r_timer + c_TW'(1);
    end

    // Next-state and next-output logic; every output is the registered image
    // of the state being entered, so gate/trig drop on the same edge as the rise.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_rr_nxt    = r_rr;
        w_grant_nxt = r_grant;
        w_ack_nxt   = '0;
        w_fault_nxt = 1'b0;
        w_gate_nxt  = 1'b0;
        w_trig_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_ARM;
                    w_grant_nxt = w_win_oh;
                    w_rr_nxt    = w_rr_inc;
                    w_timer_nxt = '0;
                    w_gate_nxt  = 1'b1;
                    w_trig_nxt  = 1'b1;
                end
            end
            ST_ARM: begin
                // A pulse already high on entry counts as the rise.
                if (pulse_in) begin
                    w_state_nxt = ST_WAIT_LO;
                    w_timer_nxt = '0;
                end else if (r_timer == c_START_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_ack_nxt   = r_grant;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_timer_nxt = w_timer_inc;
                    w_gate_nxt  = 1'b1;
                    w_trig_nxt  = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (!pulse_in) begin
                    w_state_nxt = ST_DONE;
                    w_ack_nxt   = r_grant;
                end else if (r_timer == c_WIDTH_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_ack_nxt   = r_grant;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            ST_DONE: begin
                w_grant_nxt = '0;
                w_timer_nxt = '0;
                w_state_nxt = (GAP > 0) ? ST_RECOVER : ST_IDLE;
            end
            ST_RECOVER: begin
                if (r_timer == c_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_timer_nxt = '0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and output registers; reset abandons any pulse in flight without an ack.
    always_ff @(posedge x or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_rr    <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_fault <= 1'b0;
            r_busy  <= 1'b0;
            r_gate  <= 1'b0;
            r_trig  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_rr    <= w_rr_nxt;
            r_grant <= w_grant_nxt;
            r_ack   <= w_ack_nxt;
            r_fault <= w_fault_nxt;
            r_busy  <= w_busy_nxt;
            r_gate  <= w_gate_nxt;
            r_trig  <= w_trig_nxt;
        end
    end

    assign grant  = r_grant;
    assign ack    = r_ack;
    assign fault  = r_fault;
    assign busy   = r_busy;
    assign gate_c = r_gate;
    assign trig_b = r_trig;

endmodule
`default_nettype wire

// File: tb/tb_sample_pulse_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_pulse_scheduler
//  Purpose  : Self-checking bench for sample_pulse_scheduler with a one-shot
//             model, a vector table, hand sequences and randomized transactions.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sample_pulse_scheduler;

    localparam int N_REQ    = 4;
    localparam int START_TO = 6;
    localparam int WIDTH_TO = 8;
    localparam int GAP      = 2;

    logic       x = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       fault, busy, gate_c, trig_b;
    logic       pulse_in;

    int n_chk  = 0;
    int n_fail = 0;

    // One-shot model controls: mode 0 = fires after os_delay for os_width cycles,
    // mode 1 = never fires. os_en = 0 hands pulse_in to os_manual.
    logic os_en     = 1'b1;
    logic os_manual = 1'b0;
    logic os_p      = 1'b0;
    int   os_mode   = 0;
    int   os_delay  = 0;
    int   os_width  = 1;
    int   os_st     = 0;
    int   os_cnt    = 0;
    int   m_rr;

    typedef struct {
        logic [3:0] r;
        logic [3:0] drop;
        int         mode;
        int         dly;
        int         wid;
        logic [3:0] g;
    } vec_t;
    vec_t tbl [11];

    sample_pulse_scheduler #(
        .N_REQ(N_REQ), .START_TO(START_TO), .WIDTH_TO(WIDTH_TO), .GAP(GAP)
    ) dut (
        .x(x), .reset_n(reset_n), .req(req), .grant(grant), .ack(ack),
        .fault(fault), .busy(busy), .gate_c(gate_c), .trig_b(trig_b),
        .pulse_in(pulse_in)
    );

    always #5 x = ~x;

    assign pulse_in = os_en ? os_p : os_manual;

    // One-shot behaviour: reacts to trig_b seen on the falling edge; a pulse still
    // high when the block acks (width timeout) is cut short.
    always @(negedge x) begin
        if (ack != 4'b0) begin
            os_p  = 1'b0;
            os_st = 0;
        end else begin
            case (os_st)
                0: if (trig_b && os_en && os_mode == 0) begin
                    if (os_delay == 0) begin
                        os_p   = 1'b1;
                        os_cnt = os_width - 1;
                        os_st  = 2;
                    end else begin
                        os_cnt = os_delay - 1;
                        os_st  = 1;
                    end
                end
                1: if (os_cnt == 0) begin
                    os_p   = 1'b1;
                    os_cnt = os_width - 1;
                    os_st  = 2;
                end else begin
                    os_cnt = os_cnt - 1;
                end
                default: if (os_cnt == 0) begin
                    os_p  = 1'b0;
                    os_st = 0;
                end else begin
                    os_cnt = os_cnt - 1;
                end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One full grant/pulse/ack/recover transaction with expectations derived
    // from the timing rules: ARM lasts delay+1 cycles (or START_TO on timeout),
    // WAIT_LO lasts the pulse width (or WIDTH_TO on timeout), then GAP cycles.
    task automatic run_txn(input logic [3:0] r, input logic [3:0] drop, input int mode,
                           input int dly, input int wid, input logic [3:0] exp_g,
                           input string nm);
        int   arm_exp, wait_exp, cyc, trig_cnt;
        logic f_exp, bad;
        if (mode == 1) begin
            arm_exp = START_TO; wait_exp = 0; f_exp = 1'b1;
        end else begin
            arm_exp = dly + 1;
            if (wid > WIDTH_TO) begin
                wait_exp = WIDTH_TO; f_exp = 1'b1;
            end else begin
                wait_exp = wid; f_exp = 1'b0;
            end
        end
        cyc = 0;
        while (busy && cyc < 100) begin
            @(posedge x); #1; cyc++;
        end
        chk({nm, ":idle_before"}, 32'(busy), 32'd0);
        os_mode = mode; os_delay = dly; os_width = wid;
        req = r;
        @(posedge x); #1;
        chk({nm, ":grant"}, 32'(grant), 32'(exp_g));
        chk({nm, ":busy"}, 32'(busy), 32'd1);
        chk({nm, ":gate_arm"}, 32'(gate_c), 32'd1);
        req = req & ~drop;
        trig_cnt = 0; cyc = 0; bad = 1'b0;
        while (ack == 4'b0 && cyc < 60) begin
            if (trig_b) trig_cnt++;
            if (grant != exp_g || gate_c != trig_b || fault) bad = 1'b1;
            @(posedge x); #1; cyc++;
        end
        chk({nm, ":cycles_to_ack"}, 32'(cyc), 32'(arm_exp + wait_exp));
        chk({nm, ":trig_cycles"}, 32'(trig_cnt), 32'(arm_exp));
        chk({nm, ":ack"}, 32'(ack), 32'(exp_g));
        chk({nm, ":fault"}, 32'(fault), 32'(f_exp));
        chk({nm, ":grant_in_done"}, 32'(grant), 32'(exp_g));
        chk({nm, ":stable"}, 32'(bad), 32'd0);
        req = req & ~exp_g;
        @(posedge x); #1;
        chk({nm, ":rec_grant"}, 32'(grant), 32'd0);
        chk({nm, ":rec_ack_fault"}, 32'({ack, fault}), 32'd0);
        cyc = 0;
        while (busy && cyc < 50) begin
            @(posedge x); #1; cyc++;
        end
        chk({nm, ":recover_len"}, 32'(cyc), 32'(GAP));
        req = 4'b0;
    endtask

    initial begin
        int         n;
        logic       bad;
        logic [3:0] r, g;
        int         mode, dly, wid, win;

        reset_n = 1'b0;
        req     = 4'b0;
        repeat (2) @(posedge x);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gate", 32'(gate_c), 32'd0);
        chk("rst_trig", 32'(trig_b), 32'd0);
        reset_n = 1'b1;
        @(posedge x); #1;
        chk("idle_no_req", 32'({grant, busy}), 32'd0);

        // req, drop, mode, delay, width, expected grant
        tbl[0]  = '{4'b1111, 4'b0, 0, 0, 4,  4'b0001};
        tbl[1]  = '{4'b1111, 4'b0, 0, 0, 4,  4'b0010};
        tbl[2]  = '{4'b1111, 4'b0, 0, 0, 4,  4'b0100};
        tbl[3]  = '{4'b1111, 4'b0, 0, 0, 4,  4'b1000};
        tbl[4]  = '{4'b1111, 4'b0, 0, 0, 4,  4'b0001};
        tbl[5]  = '{4'b0001, 4'b0, 0, 0, 4,  4'b0001};
        tbl[6]  = '{4'b0110, 4'b0, 1, 0, 1,  4'b0010};
        tbl[7]  = '{4'b0110, 4'b0, 0, 1, 3,  4'b0100};
        tbl[8]  = '{4'b1001, 4'b0, 0, 0, 12, 4'b1000};
        tbl[9]  = '{4'b0001, 4'b0, 0, 5, 8,  4'b0001};
        tbl[10] = '{4'b1000, 4'b0, 0, 0, 1,  4'b1000};
        for (int i = 0; i < 11; i++) begin
            run_txn(tbl[i].r, tbl[i].drop, tbl[i].mode, tbl[i].dly, tbl[i].wid,
                    tbl[i].g, $sformatf("row%0d", i));
        end

        // Reset while the pulse is high in WAIT_LO.
        os_mode = 0; os_delay = 0; os_width = 6;
        req = 4'b0010;
        @(posedge x); #1;
        chk("midrst:grant", 32'(grant), 32'b0010);
        @(posedge x); #1;
        chk("midrst:wait_lo_pins", 32'({gate_c, trig_b, busy}), 32'b001);
        @(posedge x); #1;
        reset_n = 1'b0;
        req     = 4'b0;
        #1;
        chk("midrst:outputs_zero", 32'({grant, ack, fault, busy, gate_c, trig_b}), 32'd0);
        @(posedge x); #1;
        reset_n = 1'b1;
        n = 0; bad = 1'b0;
        while ((pulse_in || os_st != 0) && n < 40) begin
            if (ack != 4'b0 || busy) bad = 1'b1;
            @(posedge x); #1; n++;
        end
        chk("midrst:no_ack", 32'(bad), 32'd0);
        chk("midrst:idle", 32'(busy), 32'd0);

        // Pointer is back at 0 after reset, so 1010 grants requester 1 first;
        // requester 1 then withdraws during ARM and is still acked.
        run_txn(4'b1010, 4'b0010, 0, 3, 3, 4'b0010, "withdraw");
        run_txn(4'b1000, 4'b0000, 0, 0, 2, 4'b1000, "after_withdraw");

        // Stale pulse already high when ARM is entered.
        os_en = 1'b0; os_manual = 1'b1;
        req = 4'b0001;
        @(posedge x); #1;
        chk("stale:grant", 32'(grant), 32'b0001);
        chk("stale:trig_arm", 32'(trig_b), 32'd1);
        @(posedge x); #1;
        chk("stale:wait_lo", 32'({trig_b, gate_c, busy, ack}), 32'b0010000);
        @(posedge x); #1;
        @(posedge x); #1;
        os_manual = 1'b0;
        @(posedge x); #1;
        chk("stale:ack", 32'(ack), 32'b0001);
        chk("stale:fault", 32'(fault), 32'd0);
        req = 4'b0;
        n = 0;
        while (busy && n < 20) begin
            @(posedge x); #1; n++;
        end
        chk("stale:idle", 32'(busy), 32'd0);
        os_en = 1'b1;

        // Randomized transactions against a round-robin reference model.
        reset_n = 1'b0;
        @(posedge x); #1;
        reset_n = 1'b1;
        m_rr = 0;
        for (int t = 0; t < 40; t++) begin
            r    = 4'($urandom_range(1, 15));
            mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
            dly  = $urandom_range(0, START_TO - 1);
            wid  = $urandom_range(1, WIDTH_TO + 2);
            win  = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (win < 0 && ((r >> ((m_rr + k) % N_REQ)) & 4'b0001) != 4'b0) begin
                    win = (m_rr + k) % N_REQ;
                end
            end
            g    = 4'b0001 << win;
            m_rr = (win + 1) % N_REQ;
            run_txn(r, 4'b0, mode, dly, wid, g, $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
